// File: rtl/mux_n_to_1_scan_if.sv
// Bus bundle for mux_n_to_1_scan: parallel lane inputs, controls and the
// registered serial output. The optional parity bit exists only when
// MUX_N_TO_1_PARITY_EN is defined.
interface mux_n_to_1_scan_if #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] din;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      en;
    logic [WIDTH-1:0]          dout;
    logic                      dout_valid;
    logic [SEL_W-1:0]          ch_out;
    logic                      frame_start;
    logic                      sel_err;
`ifdef MUX_N_TO_1_PARITY_EN
    logic                      dout_par;
`endif

    // Producer side: drives lanes and controls, observes the output.
    modport master (
        output din, sel, mode, en,
        input  dout, dout_valid, ch_out, frame_start, sel_err
`ifdef MUX_N_TO_1_PARITY_EN
        , input dout_par
`endif
    );

    // Mux side.
    modport slave (
        input  din, sel, mode, en,
        output dout, dout_valid, ch_out, frame_start, sel_err
`ifdef MUX_N_TO_1_PARITY_EN
        , output dout_par
`endif
    );
endinterface

// File: rtl/mux_n_to_1_scan.sv
// mux_n_to_1_scan: registered N:1 multiplexer with manual select and a
// time-division scan mode that dwells DWELL cycles on each channel.
// Optional feature macro: MUX_N_TO_1_PARITY_EN adds dout_par (even parity
// of the selected lane, zero whenever dout_valid is low).
module mux_n_to_1_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mux_n_to_1_scan_if.slave     bus
);
    localparam int             SLOTS      = 2 ** SEL_W;
    localparam logic [SEL_W:0] CH_COUNT   = (SEL_W + 1)'(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);
    localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);

    // Lane table padded to every encodable select value; unused slots read 0
    // so an out-of-range index can never pick up stray bits.
    logic [WIDTH-1:0] ch_data [SLOTS];

    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_lane
            if (gi < CHANNELS) begin : g_used
                assign ch_data[gi] = bus.din[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign ch_data[gi] = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             valid_reg, valid_next;
    logic [SEL_W-1:0] ch_reg, ch_next;
    logic             fs_reg, fs_next;
    logic             err_reg, err_next;
    logic [SEL_W-1:0] scan_ch_reg, scan_ch_next;
    logic [7:0]       dwell_reg, dwell_next;
    logic             mode_q_reg;
`ifdef MUX_N_TO_1_PARITY_EN
    logic             par_reg, par_next;
`endif

    // Counter values in effect this cycle: any mode change (and manual mode
    // itself) restarts the scan from channel 0, dwell 0.
    logic             restart;
    logic [SEL_W-1:0] cur_ch;
    logic [7:0]       cur_dwell;
    logic             sel_ok;

    assign restart   = (bus.mode != mode_q_reg) || !bus.mode;
    assign cur_ch    = restart ? '0 : scan_ch_reg;
    assign cur_dwell = restart ? '0 : dwell_reg;
    assign sel_ok    = {1'b0, bus.sel} < CH_COUNT;

    // Next-state decode for outputs and scan counters.
    always_comb begin
        dout_next    = dout_reg;
        ch_next      = ch_reg;
        err_next     = err_reg;
        valid_next   = 1'b0;
        fs_next      = 1'b0;
        scan_ch_next = cur_ch;
        dwell_next   = cur_dwell;
`ifdef MUX_N_TO_1_PARITY_EN
        par_next     = 1'b0;
`endif
        if (bus.en) begin
            if (!bus.mode) begin
                ch_next = bus.sel;
                if (sel_ok) begin
                    dout_next  = ch_data[bus.sel];
                    valid_next = 1'b1;
                    err_next   = 1'b0;
`ifdef MUX_N_TO_1_PARITY_EN
                    par_next   = ^ch_data[bus.sel];
`endif
                end else begin
                    dout_next  = '0;
                    err_next   = 1'b1;
                end
            end else begin
                dout_next  = ch_data[cur_ch];
                ch_next    = cur_ch;
                valid_next = 1'b1;
                err_next   = 1'b0;
                fs_next    = (cur_ch == '0) && (cur_dwell == '0);
`ifdef MUX_N_TO_1_PARITY_EN
                par_next   = ^ch_data[cur_ch];
`endif
                if (cur_dwell == DWELL_LAST) begin
                    dwell_next   = '0;
                    scan_ch_next = (cur_ch == CH_LAST) ? '0 : cur_ch + 1'b1;
                end else begin
                    dwell_next   = cur_dwell + 1'b1;
                end
            end
        end
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg    <= '0;
            valid_reg   <= 1'b0;
            ch_reg      <= '0;
            fs_reg      <= 1'b0;
            err_reg     <= 1'b0;
            scan_ch_reg <= '0;
            dwell_reg   <= '0;
            mode_q_reg  <= 1'b0;
`ifdef MUX_N_TO_1_PARITY_EN
            par_reg     <= 1'b0;
`endif
        end else begin
            dout_reg    <= dout_next;
            valid_reg   <= valid_next;
            ch_reg      <= ch_next;
            fs_reg      <= fs_next;
            err_reg     <= err_next;
            scan_ch_reg <= scan_ch_next;
            dwell_reg   <= dwell_next;
            mode_q_reg  <= bus.mode;
`ifdef MUX_N_TO_1_PARITY_EN
            par_reg     <= par_next;
`endif
        end
    end

    assign bus.dout        = dout_reg;
    assign bus.dout_valid  = valid_reg;
    assign bus.ch_out      = ch_reg;
    assign bus.frame_start = fs_reg;
    assign bus.sel_err     = err_reg;
`ifdef MUX_N_TO_1_PARITY_EN
    assign bus.dout_par    = par_reg;
`endif
endmodule

// File: tb/tb_mux_n_to_1_scan.sv
// Bench for mux_n_to_1_scan: two instances (A: 3 channels, dwell 2;
// B: 4 channels, dwell 1) share one stimulus stream and are checked every
// cycle against a position-based reference model, plus directed constants.
module tb_mux_n_to_1_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [1:0]  sel;
    logic        mode;
    logic        en;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_n_to_1_scan_if #(.WIDTH(4), .CHANNELS(3), .SEL_W(2)) if_a ();
    mux_n_to_1_scan_if #(.WIDTH(4), .CHANNELS(4), .SEL_W(2)) if_b ();

    assign if_a.din  = din[11:0];
    assign if_a.sel  = sel;
    assign if_a.mode = mode;
    assign if_a.en   = en;
    assign if_b.din  = din;
    assign if_b.sel  = sel;
    assign if_b.mode = mode;
    assign if_b.en   = en;

    mux_n_to_1_scan #(.WIDTH(4), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    mux_n_to_1_scan #(.WIDTH(4), .CHANNELS(4), .SEL_W(2), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b));

    // Reference model: a single linear scan position per instance;
    // channel = (pos / DWELL) % CHANNELS, frame boundary when pos == 0.
    int         cfg_c [2] = '{3, 4};
    int         cfg_d [2] = '{2, 1};
    int         pos   [2];
    logic       pmode [2];
    logic [3:0] e_dout  [2];
    logic       e_valid [2];
    logic [1:0] e_ch    [2];
    logic       e_fs    [2];
    logic       e_err   [2];
    logic       e_par   [2];

    function automatic logic [3:0] lane(input logic [15:0] d, input int k);
        return 4'((d >> (4 * k)) & 16'hF);
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                e_dout[i] = '0; e_valid[i] = 0; e_ch[i] = '0;
                e_fs[i] = 0; e_err[i] = 0; e_par[i] = 0;
                pos[i] = 0; pmode[i] = 0;
            end else begin
                if (mode != pmode[i] || !mode) pos[i] = 0;
                if (en) begin
                    if (!mode) begin
                        e_fs[i] = 0;
                        e_ch[i] = sel;
                        if (int'(sel) < cfg_c[i]) begin
                            e_dout[i] = lane(din, int'(sel));
                            e_valid[i] = 1; e_err[i] = 0; e_par[i] = ^e_dout[i];
                        end else begin
                            e_dout[i] = '0; e_valid[i] = 0; e_err[i] = 1; e_par[i] = 0;
                        end
                    end else begin
                        e_ch[i]    = 2'((pos[i] / cfg_d[i]) % cfg_c[i]);
                        e_dout[i]  = lane(din, int'(e_ch[i]));
                        e_valid[i] = 1; e_err[i] = 0;
                        e_fs[i]    = (pos[i] == 0);
                        e_par[i]   = ^e_dout[i];
                        pos[i]     = (pos[i] + 1) % (cfg_c[i] * cfg_d[i]);
                    end
                end else begin
                    e_valid[i] = 0; e_fs[i] = 0; e_par[i] = 0;
                end
                pmode[i] = mode;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, " a.dout"},        32'(if_a.dout),        32'(e_dout[0]));
        chk({ph, " a.dout_valid"},  32'(if_a.dout_valid),  32'(e_valid[0]));
        chk({ph, " a.ch_out"},      32'(if_a.ch_out),      32'(e_ch[0]));
        chk({ph, " a.frame_start"}, 32'(if_a.frame_start), 32'(e_fs[0]));
        chk({ph, " a.sel_err"},     32'(if_a.sel_err),     32'(e_err[0]));
        chk({ph, " b.dout"},        32'(if_b.dout),        32'(e_dout[1]));
        chk({ph, " b.dout_valid"},  32'(if_b.dout_valid),  32'(e_valid[1]));
        chk({ph, " b.ch_out"},      32'(if_b.ch_out),      32'(e_ch[1]));
        chk({ph, " b.frame_start"}, 32'(if_b.frame_start), 32'(e_fs[1]));
        chk({ph, " b.sel_err"},     32'(if_b.sel_err),     32'(e_err[1]));
`ifdef MUX_N_TO_1_PARITY_EN
        chk({ph, " a.dout_par"},    32'(if_a.dout_par),    32'(e_par[0]));
        chk({ph, " b.dout_par"},    32'(if_b.dout_par),    32'(e_par[1]));
`endif
        $display("[%0t] %s rst=%0b en=%0b mode=%0b sel=%0d din=%h | A ch=%0d d=%h v=%0b fs=%0b err=%0b | B ch=%0d d=%h v=%0b fs=%0b err=%0b",
                 $time, ph, rst, en, mode, sel, din,
                 if_a.ch_out, if_a.dout, if_a.dout_valid, if_a.frame_start, if_a.sel_err,
                 if_b.ch_out, if_b.dout, if_b.dout_valid, if_b.frame_start, if_b.sel_err);
    endtask

    // One clock: model consumes the inputs that the DUTs sample at this edge.
    task automatic step(input string ph);
        model_step();
        @(posedge clk);
        #1;
        check_all(ph);
    endtask

    task automatic bound_fail(input string tag);
        n_checks++;
        n_errors++;
        $error("FAIL %s observed=timeout expected=condition", tag);
    endtask

    int t2_exp [4]  = '{10, 11, 12, 13};
    int t4_ch  [12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
    int t4_fs  [12] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};

    initial begin
        rst = 1'b1; din = 16'h5A3C; sel = 2'd0; mode = 1'b1; en = 1'b1;

        // Reset held three cycles with scan requested and live data.
        for (int k = 0; k < 3; k++) step("reset");
        rst = 1'b0;

        // Manual sweep over every select value.
        din = 16'hDCBA; mode = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            step("manual");
            chk("t2 b.dout const", 32'(if_b.dout), 32'(t2_exp[k]));
        end

        // Invalid select on the 3-channel instance, then recovery.
        sel = 2'd3;
        step("badsel");
        chk("t3 a.sel_err const", 32'(if_a.sel_err), 32'd1);
        chk("t3 a.dout const",    32'(if_a.dout),    32'd0);
        sel = 2'd1;
        step("goodsel");
        chk("t3 a.dout const2",   32'(if_a.dout),    32'hB);

        // Scan with dwell from a fresh manual-to-scan transition.
        mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step("scan");
            chk("t4 a.ch_out const",      32'(if_a.ch_out),      32'(t4_ch[k]));
            chk("t4 a.frame_start const", 32'(if_a.frame_start), 32'(t4_fs[k]));
        end

        // Advance A until it has just finished channel 2, then stall.
        begin
            int k;
            k = 0;
            while (!(if_a.ch_out == 2'd2 && pos[0] == 0) && k < 20) begin
                step("scan2");
                k++;
            end
            if (k >= 20) bound_fail("t5 reach ch2");
        end
        en = 1'b0;
        step("stall");
        step("stall");
        chk("t5 a.ch_out hold", 32'(if_a.ch_out), 32'd2);
        en = 1'b1;
        step("unstall");
        chk("t5 a.ch_out wrap", 32'(if_a.ch_out),      32'd0);
        chk("t5 a.fs wrap",     32'(if_a.frame_start), 32'd1);

        // Mode switch mid-scan, restart, then reset mid-scan.
        begin
            int k;
            k = 0;
            while (if_a.ch_out != 2'd1 && k < 20) begin
                step("scan3");
                k++;
            end
            if (k >= 20) bound_fail("t6 reach ch1");
        end
        din = 16'h9E71; mode = 1'b0; sel = 2'd2;
        step("to_manual");
        chk("t6 a.dout lane2", 32'(if_a.dout), 32'hE);
        mode = 1'b1;
        step("to_scan");
        chk("t6 a.ch restart", 32'(if_a.ch_out),      32'd0);
        chk("t6 a.fs restart", 32'(if_a.frame_start), 32'd1);
        step("scan4");
        rst = 1'b1;
        step("midrst");
        chk("t6 b.dout rst", 32'(if_b.dout), 32'd0);
        rst = 1'b0;

        // Randomised traffic, including mode changes with en low.
        for (int k = 0; k < 400; k++) begin
            din = 16'($urandom);
            sel = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            rst = ($urandom_range(0, 49) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
